// File: rtl/csa_pkg.sv
// Shared definitions for the csa_add_sequencer block.
//   - FSM state encodings (legacy localparam constants)
//   - NIB: slice width in bits
//   - nib_idx_w(): width of the nibble index for a given operand width
package csa_pkg;

  localparam int unsigned NIB = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // ceil(log2(width/NIB)); never below 1 so the index register always exists.
  function automatic int unsigned nib_idx_w(input int unsigned width);
    int unsigned n;
    n = width / NIB;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_add_sequencer_if.sv
// Command/result bundle between a requester and csa_add_sequencer.
//   master: requester side, drives start/a/b/cin, observes busy/done/sum/cout/skip_cnt
//   slave : sequencer side
// Parameters WIDTH (operand width) and SCW (skip counter width) must match the sequencer's.
interface csa_add_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SCW   = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [SCW-1:0]   skip_cnt;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, skip_cnt
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, skip_cnt
  );

endinterface

// File: rtl/csa_slice4.sv
// 4-bit carry-skip adder slice, purely combinational.
//   a, b   : nibble operands
//   cin    : carry in
//   sum    : nibble sum
//   cout   : carry out (bypasses the ripple chain when p_grp is set)
//   p_grp  : group propagate, AND of the four bitwise XORs of a and b
module csa_slice4
  import csa_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout,
  output logic           p_grp
);

  logic [NIB-1:0] p;
  logic [NIB-1:0] g;
  logic [NIB:0]   c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NIB; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum   = p ^ c[NIB-1:0];
    p_grp = &p;
    // Skip mux: a fully propagating group passes cin straight through.
    cout  = p_grp ? cin : c[NIB];
  end

endmodule

// File: rtl/csa_add_sequencer.sv
// Multi-cycle adder: sequences one shared 4-bit carry-skip slice over a WIDTH-bit
// operand, one nibble per clock, LS nibble first.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : csa_add_sequencer_if.slave (start/a/b/cin in, busy/done/sum/cout/skip_cnt out)
// Optional feature: define CSA_SKIP_STATS_EN to count nibbles that took the skip
// path (saturating); otherwise skip_cnt is tied to 0.
module csa_add_sequencer
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SCW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  csa_add_sequencer_if.slave   bus
);

  localparam int unsigned N    = WIDTH / NIB;
  localparam int unsigned IdxW = nib_idx_w(WIDTH);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             start_acc;
  logic             run_step;

  logic [NIB-1:0]   slice_a;
  logic [NIB-1:0]   slice_b;
  logic [NIB-1:0]   slice_sum;
  logic             slice_cout;
  logic             slice_pgrp;

  assign slice_a = a_q[NIB*int'(idx_q) +: NIB];
  assign slice_b = b_q[NIB*int'(idx_q) +: NIB];

  csa_slice4 u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .p_grp (slice_pgrp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    psum_d    = psum_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    start_acc = 1'b0;
    run_step  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_d   = StRun;
          a_d       = bus.a;
          b_d       = bus.b;
          carry_d   = bus.cin;
          idx_d     = '0;
          psum_d    = '0;
        end
      end
      StRun: begin
        run_step = 1'b1;
        psum_d[NIB*int'(idx_q) +: NIB] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          // psum_d already holds the final nibble here.
          sum_d   = psum_d;
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef CSA_SKIP_STATS_EN
  logic [SCW-1:0] skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    if (start_acc) begin
      skip_d = '0;
    end else if (run_step && slice_pgrp && (skip_q != {SCW{1'b1}})) begin
      skip_d = skip_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q <= '0;
    end else begin
      skip_q <= skip_d;
    end
  end

  assign bus.skip_cnt = skip_q;
`else
  logic unused_stats;
  assign unused_stats = ^{slice_pgrp, run_step, start_acc};
  assign bus.skip_cnt = '0;
`endif

endmodule
